// File: rtl/reg_bus_responder.sv
// Register-bus responder: serves core BUSREQ codes against a small register
// file and an operand-index queue, with a host side-port to load both.
module reg_bus_responder #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned QDEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] busreq,
    input  logic [3:0] wb_data,
    input  logic       host_we,
    input  logic       host_sel,
    input  logic [3:0] host_addr,
    input  logic [7:0] host_data,
    output logic [3:0] operand_out,
    output logic [7:0] data_out,
    output logic       busack,
    output logic       err
);

    localparam int unsigned QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    localparam logic [3:0] ReqIdle  = 4'b0000;
    localparam logic [3:0] ReqRead  = 4'b0001;
    localparam logic [3:0] ReqWrite = 4'b0010;
    localparam logic [3:0] ReqNext  = 4'b0011;

    typedef enum logic {StIdle, StHold} state_e;

    state_e        state_q;
    logic [3:0]    busreq_q;
    logic [QW-1:0] ptr_q;
    logic [3:0]    operand_q;
    logic [7:0]    data_q;
    logic          busack_q;
    logic          err_q;
    logic [7:0]    regs_q  [NREGS];
    logic [3:0]    queue_q [QDEPTH];

    logic new_req;

    // A request is served only on the cycle its code first appears.
    always_comb begin
        new_req = (busreq != busreq_q) && (busreq != ReqIdle);
    end

    // FSM, request service, host writes and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            busreq_q  <= ReqIdle;
            ptr_q     <= '0;
            operand_q <= '0;
            data_q    <= '0;
            busack_q  <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            for (int i = 0; i < QDEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            busreq_q <= busreq;
            busack_q <= 1'b0;

            // Host write first so a same-edge core write to the same register wins.
            if (host_we) begin
                if (host_sel) begin
                    queue_q[host_addr[QW-1:0]] <= host_data[3:0];
                end else begin
                    regs_q[host_addr] <= host_data;
                end
            end

            case (state_q)
                StIdle: if (new_req) state_q <= StHold;
                StHold: if (busreq == ReqIdle) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            if (new_req) begin
                case (busreq)
                    ReqNext: begin
                        operand_q <= queue_q[ptr_q];
                        ptr_q     <= ptr_q + QW'(1);
                        busack_q  <= 1'b1;
                    end
                    ReqRead: begin
                        data_q   <= regs_q[operand_q];
                        busack_q <= 1'b1;
                    end
                    ReqWrite: begin
                        regs_q[operand_q] <= {4'b0000, wb_data};
                        busack_q          <= 1'b1;
                    end
                    default: err_q <= 1'b1;
                endcase
            end
        end
    end

    assign operand_out = operand_q;
    assign data_out    = data_q;
    assign busack      = busack_q;
    assign err         = err_q;

endmodule

// File: doc/reg_bus_responder.md
REG_BUS_RESPONDER -- requirements
Module: reg_bus_responder

Interface
REQ-001 Parameter: NREGS, 16, number of 8-bit registers, addressed by 4-bit operand index.
REQ-002 Parameter: QDEPTH, 8, depth of operand sequence queue (power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 busreq  input  4  BUSREQ code from core: 0000 IDLE, 0001 READ_REG, 0010 WRITE_REG, 0011 NEXT_OPERAND, others reserved.
REQ-006 wb_data  input  4  core result; written on WRITE_REG.
REQ-007 host_we  input  1  host write strobe.
REQ-008 host_sel  input  1  host target: 0 register file, 1 operand queue.
REQ-009 host_addr  input  4  host address (queue uses low log2(QDEPTH) bits).
REQ-010 host_data  input  8  host write data (queue stores low 4 bits).
REQ-011 operand_out  output  4  current operand index presented to core (registered).
REQ-012 data_out  output  8  register value presented to core (registered).
REQ-013 busack  output  1  one-cycle pulse acknowledging each served request.
REQ-014 err  output  1  sticky flag, reserved code seen.

Function
REQ-015 SHALL register busreq into busreq_q each cycle; a new request SHALL be busreq != busreq_q and busreq != 0000.
REQ-016 SHALL use FSM states IDLE and HOLD: IDLE -> HOLD on new request; HOLD -> IDLE when busreq == 0000; HOLD -> HOLD (serving it) on a different nonzero code.
REQ-017 A held unchanged code SHALL be served exactly once (no repeat on hold).
REQ-018 Service latency SHALL be one edge: the edge sampling a new code updates outputs/state and sets busack high for exactly that following cycle.
REQ-019 NEXT_OPERAND: operand_out <= queue[ptr]; ptr <= ptr+1 mod QDEPTH (wrap QDEPTH-1 -> 0).
REQ-020 READ_REG: data_out <= reg[operand_out] (operand_out value before the edge).
REQ-021 WRITE_REG: reg[operand_out] <= {4'b0000, wb_data}; data_out unchanged.
REQ-022 Reserved code as new request: err <= 1, no busack, no state change except FSM -> HOLD.
REQ-023 host_we=1 SHALL write reg[host_addr] or queue[host_addr mod QDEPTH] on the edge; independent of FSM.
REQ-024 Same-edge host write and WRITE_REG to same register: core write SHALL win.
REQ-025 Same-edge host queue write and NEXT_OPERAND reading same entry: old entry value SHALL be returned.
REQ-026 busack SHALL never be high two consecutive cycles unless busreq changed to a different nonzero code between them.

Reset
REQ-027 rst high SHALL immediately force operand_out=0, data_out=0x00, busack=0, err=0, ptr=0, busreq_q=0000, FSM=IDLE, all registers and queue entries 0.
REQ-028 Reset asserted mid-request SHALL abort it; after release a still-present nonzero busreq SHALL be treated as a new request.
REQ-029 err SHALL clear only by reset.

Verification
REQ-030 Reset: assert rst during HOLD with busack high -> all outputs 0 same cycle; release with busreq=0011 -> busack on next edge, operand_out=queue[0].
REQ-031 Host reg1=0x04, queue[0]=1; busreq 0011 -> operand_out=1, busack 1 cycle; then busreq 0001 -> data_out=0x04.
REQ-032 operand_out=1, wb_data=6, busreq 0010 -> reg1=0x06; busreq 0000 then 0001 -> data_out=0x06.
REQ-033 Queue loaded 0..7; nine NEXT_OPERAND requests separated by 0000 -> operand_out 0,1,...,7,0 (wrap).
REQ-034 busreq 0011 held 5 cycles -> exactly one busack, ptr advanced by 1.
REQ-035 busreq 0101 -> err=1, busack 0; subsequent valid requests served normally, err stays 1 until rst.
